// File: rtl/rot_cordic_ctrl.sv
// rot_cordic_ctrl: sequencing controller for an external vectoring CORDIC datapath.
// Accepts one I/Q sample, runs N_ITER micro-rotations driving y toward zero, and
// returns magnitude (final x) and phase (final z) on a valid/ready handshake.
// Optional build macro ROT_CORDIC_CTRL_SKID_EN adds a one-entry input skid buffer
// so a new sample can be accepted while the current one is still in flight.

module rot_cordic_ctrl #(
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned WIDTH_WIRE  = 18,
  parameter int unsigned N_ITER      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_WIRE-1:0]  x_in,
  input  logic [WIDTH_WIRE-1:0]  y_in,
  output logic [WIDTH_WIRE-1:0]  dp_x,
  output logic [WIDTH_WIRE-1:0]  dp_y,
  output logic                   dp_ce,
  output logic                   dp_mux_sel,
  output logic                   dp_sign_in,
  output logic [COUNT_WIDTH-1:0] dp_shift_bit,
  input  logic                   dp_sign_out,
  input  logic [WIDTH_WIRE-1:0]  dp_x_out,
  input  logic [WIDTH_WIRE-1:0]  dp_y_out,
  input  logic [WIDTH-1:0]       dp_z_out,
  output logic [WIDTH_WIRE-1:0]  mag_out,
  output logic [WIDTH-1:0]       phase_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  localparam logic [COUNT_WIDTH-1:0] KLast = COUNT_WIDTH'(N_ITER - 1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] k_q, k_d;
  logic                   load_new;
  logic [WIDTH_WIRE-1:0]  load_x, load_y;
  logic                   capture;

  // Residual y is not needed by a vectoring controller.
  logic unused_dp_y_out;
  assign unused_dp_y_out = ^dp_y_out;

`ifdef ROT_CORDIC_CTRL_SKID_EN
  logic                  skid_full_q;
  logic [WIDTH_WIRE-1:0] skid_x_q, skid_y_q;
  logic                  skid_push, skid_pop;

  // Buffer while busy, except on the DONE-exit edge where the input loads directly.
  assign skid_push = in_valid && !skid_full_q && (state_q != StIdle) &&
                     !((state_q == StDone) && out_ready);
  assign skid_pop  = (state_q == StDone) && out_ready && skid_full_q;
  assign in_ready  = !rst && !skid_full_q;

  // Skid buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_x_q    <= '0;
      skid_y_q    <= '0;
    end else if (skid_push) begin
      skid_full_q <= 1'b1;
      skid_x_q    <= x_in;
      skid_y_q    <= y_in;
    end else if (skid_pop) begin
      skid_full_q <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (state_q == StIdle);
`endif

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);

  // Next-state, iteration index and datapath control decode.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    load_new     = 1'b0;
    load_x       = x_in;
    load_y       = y_in;
    capture      = 1'b0;
    dp_ce        = 1'b0;
    dp_mux_sel   = 1'b0;
    dp_shift_bit = '0;
    dp_sign_in   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load_new = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        dp_ce   = 1'b1;
        k_d     = '0;
        state_d = StIter;
      end
      StIter: begin
        dp_ce        = 1'b1;
        dp_mux_sel   = 1'b1;
        dp_shift_bit = k_q;
        // Rotate against the sign of y to drive it toward zero.
        dp_sign_in   = dp_sign_out;
        if (k_q == KLast) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
`ifdef ROT_CORDIC_CTRL_SKID_EN
          // Buffered sample is older than anything on the input, so it goes first.
          if (skid_full_q) begin
            load_new = 1'b1;
            load_x   = skid_x_q;
            load_y   = skid_y_q;
            state_d  = StLoad;
          end else if (in_valid) begin
            load_new = 1'b1;
            state_d  = StLoad;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and iteration index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Sample registers feeding the datapath; held for the whole computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_x <= '0;
      dp_y <= '0;
    end else if (load_new) begin
      dp_x <= load_x;
      dp_y <= load_y;
    end
  end

  // Result capture on the last micro-rotation; held stable through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_out   <= '0;
      phase_out <= '0;
    end else if (capture) begin
      mag_out   <= dp_x_out;
      phase_out <= dp_z_out;
    end
  end

endmodule

// File: tb/tb_rot_cordic_ctrl.sv
// Bench for rot_cordic_ctrl. A small stub datapath stands in for the CORDIC:
// LOAD copies x and y[WIDTH-1:0] into x/z accumulators, each ITER cycle adds 1 to x
// and (shift+1) to z. A correctly timed capture therefore sees x+(N-1) and
// y+N(N-1)/2, which makes any off-by-one in sequencing or capture visible.

module tb_rot_cordic_ctrl;

  localparam int CW = 4;
  localparam int W  = 16;
  localparam int WW = 18;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] x_in, y_in;
  logic [WW-1:0] dp_x, dp_y;
  logic          dp_ce, dp_mux_sel, dp_sign_in;
  logic [CW-1:0] dp_shift_bit;
  logic          dp_sign_out;
  logic [WW-1:0] dp_x_out, dp_y_out;
  logic [W-1:0]  dp_z_out;
  logic [WW-1:0] mag_out;
  logic [W-1:0]  phase_out;
  logic          out_valid, out_ready, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [WW+W-1:0] sb[$];

  rot_cordic_ctrl #(
    .COUNT_WIDTH(CW), .WIDTH(W), .WIDTH_WIRE(WW), .N_ITER(N)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .dp_x(dp_x), .dp_y(dp_y), .dp_ce(dp_ce),
    .dp_mux_sel(dp_mux_sel), .dp_sign_in(dp_sign_in), .dp_shift_bit(dp_shift_bit),
    .dp_sign_out(dp_sign_out), .dp_x_out(dp_x_out), .dp_y_out(dp_y_out),
    .dp_z_out(dp_z_out), .mag_out(mag_out), .phase_out(phase_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stub datapath.
  logic [WW-1:0] sx;
  logic [W-1:0]  sz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sz <= '0;
    end else if (dp_ce) begin
      if (!dp_mux_sel) begin
        sx <= dp_x;
        sz <= dp_y[W-1:0];
      end else begin
        sx <= sx + 1'b1;
        sz <= sz + W'(dp_shift_bit) + 16'd1;
      end
    end
  end
  assign dp_x_out    = sx;
  assign dp_y_out    = ~sx;
  assign dp_z_out    = sz;
  assign dp_sign_out = sx[0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result();
    logic [WW+W-1:0] e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("mag_out", 64'(mag_out), 64'(e[WW+W-1:W]));
      chk("phase_out", 64'(phase_out), 64'(e[W-1:0]));
    end
  endtask

  function automatic logic [WW+W-1:0] expect_of(input logic [WW-1:0] x, input logic [WW-1:0] y);
    logic [WW-1:0] m;
    logic [W-1:0]  p;
    m = WW'(x + WW'(N - 1));
    p = W'(y) + W'(N * (N - 1) / 2);
    return {m, p};
  endfunction

  // Control-sequence monitor: shift index walk, sign forwarding, LOAD and idle controls.
  int  it_cnt = 0;
  bit  in_iter = 0;
  always @(negedge clk) begin
    if (rst) begin
      it_cnt  = 0;
      in_iter = 0;
    end else if (dp_ce && dp_mux_sel) begin
      chk("shift_bit", 64'(dp_shift_bit), 64'(it_cnt));
      chk("sign_in", 64'(dp_sign_in), 64'(dp_sign_out));
      it_cnt++;
      in_iter = 1;
    end else begin
      if (in_iter) chk("iter_count", 64'(it_cnt), 64'(N));
      in_iter = 0;
      it_cnt  = 0;
      if (dp_ce) chk("load_ctl", 64'({dp_shift_bit, dp_sign_in}), 64'd0);
      if (!busy || out_valid) chk("ce_idle_done", 64'(dp_ce), 64'd0);
    end
  end

  task automatic run_sample(input logic [WW-1:0] x, input logic [WW-1:0] y, input int hold);
    int lat;
    logic [WW-1:0] m;
    logic [W-1:0]  p;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    x_in      = x;
    y_in      = y;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    sb.push_back(expect_of(x, y));
    chk("dp_x", 64'(dp_x), 64'(x));
    chk("dp_y", 64'(dp_y), 64'(y));
    chk("busy", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(N + 1));
    chk_result();
    chk("dp_x_held", 64'(dp_x), 64'(x));
    if (hold > 0) begin
      m = mag_out;
      p = phase_out;
      repeat (hold) begin
        tick();
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_mag", 64'(mag_out), 64'(m));
        chk("hold_phase", 64'(phase_out), 64'(p));
`ifdef ROT_CORDIC_CTRL_SKID_EN
        chk("hold_in_ready", 64'(in_ready), 64'd1);
`else
        chk("hold_in_ready", 64'(in_ready), 64'd0);
`endif
      end
      out_ready = 1'b1;
    end
    tick();
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t1, t2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mag", 64'(mag_out), 64'd0);
    chk("rst_phase", 64'(phase_out), 64'd0);
    chk("rst_dp_xy", 64'({dp_x, dp_y}), 64'd0);
    chk("rst_ce", 64'(dp_ce), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    run_sample(18'd1000, 18'd0, 0);
    run_sample(18'd0, WW'(-1000), 0);
    run_sample(18'd300, WW'(-77), 20);

    // Reset in the middle of ITER discards the sample.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = 18'd555;
    y_in      = 18'd444;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!(dp_mux_sel && dp_shift_bit == 4'd7) && n < 40) begin
      tick();
      n++;
    end
    chk("reach_k7", 64'(dp_shift_bit), 64'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_res", 64'({mag_out, phase_out}), 64'd0);
    chk("mid_rst_dp", 64'({dp_x, dp_y}), 64'd0);
    chk("mid_rst_ctl", 64'({dp_ce, dp_mux_sel, dp_shift_bit}), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (20) begin
      tick();
      chk("no_stale_valid", 64'(out_valid), 64'd0);
    end
    run_sample(18'd2047, 18'd12, 0);

`ifdef ROT_CORDIC_CTRL_SKID_EN
    // Two samples back to back: second is buffered and follows after one DONE cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = 18'd10;
    y_in      = 18'd20;
    tick();
    sb.push_back(expect_of(18'd10, 18'd20));
    x_in = 18'd30;
    y_in = WW'(-40);
    chk("skid_ready", 64'(in_ready), 64'd1);
    tick();
    sb.push_back(expect_of(18'd30, WW'(-40)));
    in_valid = 1'b0;
    chk("skid_full", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    t1 = cyc;
    chk_result();
    tick();
    chk("skid_reload", 64'({out_valid, busy}), 64'b01);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    t2 = cyc;
    chk("skid_gap", 64'(t2 - t1), 64'(N + 2));
    chk_result();
    tick();
    chk("skid_idle", 64'(busy), 64'd0);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
